// File: rtl/jtmikie_dwnld_remap.sv
// ioctl download pre-processor: classifies bytes by ROM region, remaps tiles and pulses done after drain.
// Define JTMIKIE_DWNLD_CHK_EN to build the byte_cnt/checksum tracking; otherwise both read as 0.
//
// state    | meaning
// ST_IDLE  | waiting for downloading to rise
// ST_LOAD  | accepting rising edges of ioctl_wr
// ST_FLUSH | two cycles letting in-flight bytes leave the pipeline
// ST_DONE  | one-cycle done pulse, then back to idle
module jtmikie_dwnld_remap #(
    parameter logic [21:0] SCR_START  = 22'h18000,
    parameter logic [21:0] OBJ_START  = 22'h20000,
    parameter logic [24:0] PROM_START = 25'h30000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    output logic [24:0] dwn_addr,
    output logic [7:0]  dwn_data,
    output logic        dwn_wr,
    output logic [1:0]  region,
    output logic [24:0] byte_cnt,
    output logic [15:0] checksum,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] RG_CODE = 2'd0;
    localparam logic [1:0] RG_SCR  = 2'd1;
    localparam logic [1:0] RG_OBJ  = 2'd2;
    localparam logic [1:0] RG_PROM = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        flush_cnt_q, flush_cnt_d;
    logic        dl_q, wr_q;
    logic        s1_vld_q, s1_vld_d;
    logic [24:0] s1_addr_q, s1_addr_d;
    logic [7:0]  s1_data_q, s1_data_d;
    logic [1:0]  s1_rgn_q, s1_rgn_d;
    logic        dwn_wr_q, dwn_wr_d;
    logic [24:0] dwn_addr_q, dwn_addr_d;
    logic [7:0]  dwn_data_q, dwn_data_d;
    logic [1:0]  region_q, region_d;
    logic        dl_rise, dl_fall, accept;

    assign dl_rise = downloading & ~dl_q;
    assign dl_fall = ~downloading & dl_q;
    assign accept  = ioctl_wr & ~wr_q & (state_q == ST_LOAD);

    function automatic logic [24:0] obj_remap(input logic [24:0] a);
        logic [24:0] o;
        o      = a;
        o[15]  = a[0];
        o[14]  = a[15];
        o[0]   = ~a[14];
        o[2:1] = a[5:4] + 2'd1;
        o[6:3] = {a[6], a[3:1]};
        return o;
    endfunction

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE:  if (dl_rise) state_d = ST_LOAD;
            ST_LOAD: begin
                if (dl_fall) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 1'b0) state_d = ST_DONE;
                else                     flush_cnt_d = flush_cnt_q - 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // PROM is tested first on the full address, so the object test only needs the lower bound
    always_comb begin
        s1_vld_d  = accept;
        s1_addr_d = s1_addr_q;
        s1_data_d = s1_data_q;
        s1_rgn_d  = s1_rgn_q;
        if (accept) begin
            s1_addr_d = ioctl_addr;
            s1_data_d = ioctl_dout;
            if (ioctl_addr >= PROM_START)           s1_rgn_d = RG_PROM;
            else if (ioctl_addr[21:0] >= OBJ_START) s1_rgn_d = RG_OBJ;
            else if (ioctl_addr[21:0] >= SCR_START) s1_rgn_d = RG_SCR;
            else                                    s1_rgn_d = RG_CODE;
        end
    end

    always_comb begin
        dwn_wr_d   = s1_vld_q;
        dwn_addr_d = dwn_addr_q;
        dwn_data_d = dwn_data_q;
        region_d   = region_q;
        if (s1_vld_q) begin
            region_d   = s1_rgn_q;
            dwn_addr_d = s1_addr_q;
            dwn_data_d = s1_data_q;
            case (s1_rgn_q)
                RG_SCR:  dwn_data_d = {s1_data_q[3:0], s1_data_q[7:4]};
                RG_OBJ:  dwn_addr_d = obj_remap(s1_addr_q);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 1'b0;
            dl_q        <= 1'b0;
            wr_q        <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            s1_rgn_q    <= '0;
            dwn_wr_q    <= 1'b0;
            dwn_addr_q  <= '0;
            dwn_data_q  <= '0;
            region_q    <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            dl_q        <= downloading;
            wr_q        <= ioctl_wr;
            s1_vld_q    <= s1_vld_d;
            s1_addr_q   <= s1_addr_d;
            s1_data_q   <= s1_data_d;
            s1_rgn_q    <= s1_rgn_d;
            dwn_wr_q    <= dwn_wr_d;
            dwn_addr_q  <= dwn_addr_d;
            dwn_data_q  <= dwn_data_d;
            region_q    <= region_d;
        end
    end

`ifdef JTMIKIE_DWNLD_CHK_EN
    logic [24:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] checksum_q, checksum_d;
    logic        enter_load;

    assign enter_load = (state_q == ST_IDLE) & dl_rise;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        checksum_d = checksum_q;
        if (enter_load) begin
            byte_cnt_d = '0;
            checksum_d = '0;
        end else if (accept) begin
            if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 25'd1;
            checksum_d = checksum_q + {8'd0, ioctl_dout};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            checksum_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            checksum_q <= checksum_d;
        end
    end

    assign byte_cnt = byte_cnt_q;
    assign checksum = checksum_q;
`else
    assign byte_cnt = '0;
    assign checksum = '0;
`endif

    assign dwn_wr   = dwn_wr_q;
    assign dwn_addr = dwn_addr_q;
    assign dwn_data = dwn_data_q;
    assign region   = region_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_jtmikie_dwnld_remap.sv
// Directed bench for jtmikie_dwnld_remap; expectations follow JTMIKIE_DWNLD_CHK_EN when it is defined.
module tb_jtmikie_dwnld_remap;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] dwn_addr;
    logic [7:0]  dwn_data;
    logic        dwn_wr;
    logic [1:0]  region;
    logic [24:0] byte_cnt;
    logic [15:0] checksum;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef JTMIKIE_DWNLD_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    jtmikie_dwnld_remap dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wr    (ioctl_wr),
        .dwn_addr    (dwn_addr),
        .dwn_data    (dwn_data),
        .dwn_wr      (dwn_wr),
        .region      (region),
        .byte_cnt    (byte_cnt),
        .checksum    (checksum),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] v);
        return CHK_EN ? v : 32'd0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".dwn_addr"}, 32'(dwn_addr), 32'd0);
        check({tag, ".dwn_data"}, 32'(dwn_data), 32'd0);
        check({tag, ".dwn_wr"},   32'(dwn_wr),   32'd0);
        check({tag, ".region"},   32'(region),   32'd0);
        check({tag, ".byte_cnt"}, 32'(byte_cnt), 32'd0);
        check({tag, ".checksum"}, 32'(checksum), 32'd0);
        check({tag, ".busy"},     32'(busy),     32'd0);
        check({tag, ".done"},     32'(done),     32'd0);
    endtask

    task automatic start_dl(input string tag);
        downloading = 1'b1;
        @(negedge clk);
        check({tag, ".busy"}, 32'(busy), 32'd1);
    endtask

    // one-cycle strobe, leaves time at the negedge where dwn_wr is expected high
    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
        @(negedge clk);
    endtask

    task automatic xfer(input string tag, input logic [24:0] a, input logic [7:0] d,
                        input logic [24:0] ea, input logic [7:0] ed, input logic [1:0] er);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        check({tag, ".wr_early"}, 32'(dwn_wr), 32'd0);
        ioctl_wr = 1'b0;
        @(negedge clk);
        check({tag, ".wr"},     32'(dwn_wr),   32'd1);
        check({tag, ".addr"},   32'(dwn_addr), 32'(ea));
        check({tag, ".data"},   32'(dwn_data), 32'(ed));
        check({tag, ".region"}, 32'(region),   32'(er));
        @(negedge clk);
        check({tag, ".wr_off"}, 32'(dwn_wr),   32'd0);
        check({tag, ".hold"},   32'(dwn_addr), 32'(ea));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int dones;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        start_dl("dl1");
        check("dl1.cnt_clear", 32'(byte_cnt), 32'd0);
        xfer("scroll", 25'h18005, 8'hA5, 25'h18005, 8'h5A, 2'd1);
        xfer("obj1",   25'h20000, 8'h3C, 25'h20003, 8'h3C, 2'd2);
        xfer("obj2",   25'h24031, 8'h81, 25'h28000, 8'h81, 2'd2);
        xfer("prom",   25'h30010, 8'h0F, 25'h30010, 8'h0F, 2'd3);
        xfer("code",   25'h00100, 8'h77, 25'h00100, 8'h77, 2'd0);
        check("dl1.byte_cnt", 32'(byte_cnt), cnt_exp(32'd5));
        check("dl1.checksum", 32'(checksum), cnt_exp(32'h1E8));

        downloading = 1'b0;
        @(negedge clk);
        check("dl1.flush1.done", 32'(done), 32'd0);
        check("dl1.flush1.busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("dl1.flush2.done", 32'(done), 32'd0);
        @(negedge clk);
        check("dl1.done",        32'(done), 32'd1);
        @(negedge clk);
        check("dl1.done_off",    32'(done), 32'd0);
        check("dl1.idle_busy",   32'(busy), 32'd0);

        // held strobe: one write only
        start_dl("dl2");
        check("dl2.cnt_clear", 32'(byte_cnt), 32'd0);
        check("dl2.sum_clear", 32'(checksum), 32'd0);
        ioctl_addr = 25'h00200;
        ioctl_dout = 8'h11;
        ioctl_wr   = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (dwn_wr) pulses++;
        end
        ioctl_wr = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (dwn_wr) pulses++;
        end
        check("held.pulses",   32'(pulses),   32'd1);
        check("held.byte_cnt", 32'(byte_cnt), cnt_exp(32'd1));
        downloading = 1'b0;
        repeat (5) @(negedge clk);
        check("dl2.idle_busy", 32'(busy), 32'd0);

        // checksum wrap, then a strobe coinciding with the falling edge of downloading
        start_dl("dl3");
        for (int i = 0; i < 257; i++) wr_byte(25'(i), 8'hFF);
        check("wrap.sum_ffff", 32'(checksum), cnt_exp(32'hFFFF));
        check("wrap.cnt_257",  32'(byte_cnt), cnt_exp(32'd257));
        wr_byte(25'd257, 8'h01);
        check("wrap.sum_0",    32'(checksum), 32'd0);
        check("wrap.cnt_258",  32'(byte_cnt), cnt_exp(32'd258));

        ioctl_addr  = 25'h18010;
        ioctl_dout  = 8'h12;
        ioctl_wr    = 1'b1;
        downloading = 1'b0;
        @(negedge clk);
        check("edge.wr_early", 32'(dwn_wr), 32'd0);
        check("edge.done1",    32'(done),   32'd0);
        ioctl_wr = 1'b0;
        @(negedge clk);
        check("edge.wr",       32'(dwn_wr),   32'd1);
        check("edge.data",     32'(dwn_data), 32'h21);
        check("edge.region",   32'(region),   32'd1);
        check("edge.done2",    32'(done),     32'd0);
        ioctl_addr = 25'h00050;
        ioctl_dout = 8'h44;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        check("edge.done3",    32'(done),   32'd1);
        check("edge.busy3",    32'(busy),   32'd1);
        check("edge.wr3",      32'(dwn_wr), 32'd0);
        ioctl_wr = 1'b0;
        @(negedge clk);
        check("edge.done4",    32'(done),     32'd0);
        check("edge.busy4",    32'(busy),     32'd0);
        check("flush_drop.wr", 32'(dwn_wr),   32'd0);
        check("edge.byte_cnt", 32'(byte_cnt), cnt_exp(32'd259));
        check("edge.checksum", 32'(checksum), cnt_exp(32'h12));
        @(negedge clk);

        // reset with a byte sitting in stage 1
        start_dl("dl4");
        ioctl_addr = 25'h18020;
        ioctl_dout = 8'h99;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        rst_n       = 1'b0;
        ioctl_wr    = 1'b0;
        downloading = 1'b0;
        #1;
        check_all_zero("rst_mid");
        pulses = 0;
        dones  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (dwn_wr) pulses++;
            if (done) dones++;
        end
        check("rst_mid.pulses", 32'(pulses), 32'd0);
        check("rst_mid.dones",  32'(dones),  32'd0);
        check_all_zero("rst_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
